// File: rtl/key_step_ctrl.sv
// Key front end: synchronises and debounces the step and load keys and turns a debounced step press
// into a one-cycle step or load pulse. Define AUTO_REPEAT_EN to add auto-repeat of step pulses while the key is held.
module key_step_ctrl #(
  parameter int DEB_CYCLES    = 16,
  parameter int REPEAT_CYCLES = 64
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       key_step_i,
  input  logic       key_load_i,
  input  logic [7:0] seed_i,
  output logic       step_o,
  output logic       load_o,
  output logic [7:0] seed_o,
  output logic [1:0] key_state_o,
  output logic [3:0] dbg_fsm_o
);

  localparam int CW = $clog2(DEB_CYCLES);
  localparam logic [CW-1:0] TERM = CW'(DEB_CYCLES - 1);

  // Bit 1 of the encoding is the debounced level; bit 0 means a count is in progress.
  typedef enum logic [1:0] {
    ST_LOW       = 2'b00,
    ST_RISE_WAIT = 2'b01,
    ST_HIGH      = 2'b10,
    ST_FALL_WAIT = 2'b11
  } key_fsm_t;

  // Index 0 is the step key, index 1 the load key.
  logic [1:0]    r_key_s1, r_key_s2;
  logic [7:0]    r_seed_s1, r_seed_s2;
  key_fsm_t      r_state   [2];
  key_fsm_t      w_state_nxt [2];
  logic [CW-1:0] r_cnt     [2];
  logic [CW-1:0] w_cnt_nxt [2];
  logic [1:0]    w_rise;
  logic          w_step_stable, w_load_stable;
  logic          w_step_pulse, w_load_pulse, w_rep_fire;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_key_s1  <= '0;
      r_key_s2  <= '0;
      r_seed_s1 <= '0;
      r_seed_s2 <= '0;
    end else begin
      r_key_s1  <= {key_load_i, key_step_i};
      r_key_s2  <= r_key_s1;
      r_seed_s1 <= seed_i;
      r_seed_s2 <= r_seed_s1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int k = 0; k < 2; k++) begin
        r_state[k] <= ST_LOW;
        r_cnt[k]   <= '0;
      end
    end else begin
      for (int k = 0; k < 2; k++) begin
        r_state[k] <= w_state_nxt[k];
        r_cnt[k]   <= w_cnt_nxt[k];
      end
    end
  end

  // Any sample equal to the stable level drops the count back to zero.
  always_comb begin
    for (int k = 0; k < 2; k++) begin
      w_state_nxt[k] = r_state[k];
      w_cnt_nxt[k]   = '0;
      w_rise[k]      = 1'b0;
      case (r_state[k])
        ST_LOW: begin
          if (r_key_s2[k]) begin
            w_state_nxt[k] = ST_RISE_WAIT;
            w_cnt_nxt[k]   = r_cnt[k] + CW'(1);
          end
        end
        ST_RISE_WAIT: begin
          if (!r_key_s2[k]) begin
            w_state_nxt[k] = ST_LOW;
          end else if (r_cnt[k] == TERM) begin
            w_state_nxt[k] = ST_HIGH;
            w_rise[k]      = 1'b1;
          end else begin
            w_cnt_nxt[k]   = r_cnt[k] + CW'(1);
          end
        end
        ST_HIGH: begin
          if (!r_key_s2[k]) begin
            w_state_nxt[k] = ST_FALL_WAIT;
            w_cnt_nxt[k]   = r_cnt[k] + CW'(1);
          end
        end
        ST_FALL_WAIT: begin
          if (r_key_s2[k]) begin
            w_state_nxt[k] = ST_HIGH;
          end else if (r_cnt[k] == TERM) begin
            w_state_nxt[k] = ST_LOW;
          end else begin
            w_cnt_nxt[k]   = r_cnt[k] + CW'(1);
          end
        end
        default: w_state_nxt[k] = ST_LOW;
      endcase
    end
  end

  assign w_step_stable = r_state[0][1];
  assign w_load_stable = r_state[1][1];
  // The load level before this edge decides the pulse type.
  assign w_step_pulse  = w_rise[0] & ~w_load_stable;
  assign w_load_pulse  = w_rise[0] &  w_load_stable;

`ifdef AUTO_REPEAT_EN
  localparam int RW = $clog2(REPEAT_CYCLES);
  localparam logic [RW-1:0] RTERM = RW'(REPEAT_CYCLES - 1);

  logic [RW-1:0] r_rep_cnt;
  logic          r_rep_arm;

  assign w_rep_fire = r_rep_arm & w_step_stable & ~w_load_stable & (r_rep_cnt == RTERM);

  // Armed only by a step-type pulse, so a load press never repeats.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_rep_cnt <= '0;
      r_rep_arm <= 1'b0;
    end else if (w_step_pulse) begin
      r_rep_cnt <= '0;
      r_rep_arm <= 1'b1;
    end else if (!w_step_stable || w_load_stable) begin
      r_rep_cnt <= '0;
      r_rep_arm <= 1'b0;
    end else if (r_rep_arm) begin
      r_rep_cnt <= w_rep_fire ? '0 : r_rep_cnt + RW'(1);
    end
  end
`else
  assign w_rep_fire = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      step_o <= 1'b0;
      load_o <= 1'b0;
      seed_o <= '0;
    end else begin
      step_o <= w_step_pulse | w_rep_fire;
      load_o <= w_load_pulse;
      if (w_load_pulse) seed_o <= r_seed_s2;
    end
  end

  assign key_state_o = {w_load_stable, w_step_stable};
  assign dbg_fsm_o   = {r_state[1], r_state[0]};

endmodule

// File: tb/tb_key_step_ctrl.sv
// Bench for key_step_ctrl: expected pulses (edge, type, seed) are queued when keys are driven
// and matched against every pulse seen on step_o/load_o. AUTO_REPEAT_EN selects repeat expectations.
module tb_key_step_ctrl;
  localparam int DEB = 16;
  localparam int REP = 64;
  localparam int LAT = DEB + 2;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       key_step_i = 1'b0;
  logic       key_load_i = 1'b0;
  logic [7:0] seed_i = 8'h00;
  logic       step_o, load_o;
  logic [7:0] seed_o;
  logic [1:0] key_state_o;
  logic [3:0] dbg_fsm_o;

  logic [41:0] exp_q[$];
  int unsigned edge_cnt = 0;
  int          vectors = 0;
  int          miscompares = 0;
  logic [7:0]  exp_seed = 8'h00;

  key_step_ctrl #(.DEB_CYCLES(DEB), .REPEAT_CYCLES(REP)) u_dut (
    .clk(clk), .rst(rst), .key_step_i(key_step_i), .key_load_i(key_load_i),
    .seed_i(seed_i), .step_o(step_o), .load_o(load_o), .seed_o(seed_o),
    .key_state_o(key_state_o), .dbg_fsm_o(dbg_fsm_o)
  );

  // clock / reset
  always #5 clk = ~clk;
  always @(posedge clk) edge_cnt <= edge_cnt + 1;

  initial begin
    #200000;
    $display("FAIL watchdog: sim time expired with %0d expected pulses outstanding", exp_q.size());
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (edge %0d)", tag, got, exp, edge_cnt);
    end
  endtask

  // driver tasks
  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic push_pulse(input int unsigned at, input logic ld);
    exp_q.push_back({at, ld, ~ld, exp_seed});
  endtask

  task automatic press_step_clean(input int hold);
    int unsigned e0;
    e0 = edge_cnt;
    key_step_i = 1'b1;
    push_pulse(e0 + LAT, 1'b0);
    cyc(LAT);
    check("ks_pressed", {62'd0, key_state_o}, 64'd1);
    cyc(hold);
    key_step_i = 1'b0;
    cyc(LAT + 22);
    check("ks_released", {62'd0, key_state_o}, 64'd0);
  endtask

  // scoreboard
  always @(negedge clk) begin
    if (rst && (step_o || load_o)) begin
      check("one_hot", {63'd0, step_o & load_o}, 64'd0);
      if (exp_q.size() == 0)
        check("spurious", {22'd0, edge_cnt, load_o, step_o, seed_o}, 64'd0);
      else
        check("pulse", {22'd0, edge_cnt, load_o, step_o, seed_o}, {22'd0, exp_q.pop_front()});
    end
  end

  initial begin
    int unsigned e0;
    int unsigned t0;

    // reset with inputs toggling
    for (int i = 0; i < 8; i++) begin
      key_step_i = 1'($urandom_range(0, 1));
      key_load_i = 1'($urandom_range(0, 1));
      seed_i     = 8'($urandom_range(0, 255));
      cyc(2);
      check("rst_outs", {52'd0, step_o, load_o, seed_o, key_state_o}, 64'd0);
    end
    key_step_i = 1'b0;
    key_load_i = 1'b0;
    seed_i     = 8'h00;
    cyc(2);
    rst = 1'b1;
    cyc(100);
    check("idle_ks", {62'd0, key_state_o}, 64'd0);
    check("drain_idle", 64'(exp_q.size()), 64'd0);

    // clean press, hold check of FSM state
    e0 = edge_cnt;
    key_step_i = 1'b1;
    push_pulse(e0 + LAT, 1'b0);
    cyc(LAT + 5);
    check("fsm_high", {60'd0, dbg_fsm_o}, 64'h2);
    cyc(15);
    key_step_i = 1'b0;
    cyc(LAT + 22);
    check("ks_clean_rel", {62'd0, key_state_o}, 64'd0);
    check("drain_clean", 64'(exp_q.size()), 64'd0);

    // bouncing press: toggles every 5 cycles, then holds high
    for (int i = 0; i < 12; i++) begin
      key_step_i = (i % 2 == 0);
      cyc(5);
    end
    press_step_clean(20);
    check("drain_bounce", 64'(exp_q.size()), 64'd0);

    // load select held, then press produces a load pulse with the seed
    key_load_i = 1'b1;
    seed_i     = 8'hA5;
    cyc(40);
    check("ks_load", {62'd0, key_state_o}, 64'd2);
    exp_seed = 8'hA5;
    e0 = edge_cnt;
    key_step_i = 1'b1;
    push_pulse(e0 + LAT, 1'b1);
    cyc(LAT + 10);
    seed_i = 8'h3C;
    cyc(10);
    check("seed_hold", {56'd0, seed_o}, 64'hA5);
    key_step_i = 1'b0;
    cyc(LAT + 22);
    key_load_i = 1'b0;
    cyc(LAT + 22);
    check("seed_after_load", {56'd0, seed_o}, 64'hA5);
    check("drain_load", 64'(exp_q.size()), 64'd0);

    // reset mid-debounce with key held
    key_step_i = 1'b1;
    cyc(10);
    rst = 1'b0;
    exp_seed = 8'h00;
    cyc(2);
    check("rst_mid", {52'd0, step_o, load_o, seed_o, key_state_o}, 64'd0);
    rst = 1'b1;
    t0 = edge_cnt;
    push_pulse(t0 + LAT, 1'b0);
    cyc(LAT + 20);
    key_step_i = 1'b0;
    cyc(LAT + 22);
    check("drain_rstmid", 64'(exp_q.size()), 64'd0);

    // both keys settle on the same edge: old load level gives a step pulse
    e0 = edge_cnt;
    key_step_i = 1'b1;
    key_load_i = 1'b1;
    push_pulse(e0 + LAT, 1'b0);
    cyc(LAT + 5);
    check("ks_both", {62'd0, key_state_o}, 64'd3);
    key_step_i = 1'b0;
    key_load_i = 1'b0;
    cyc(LAT + 22);
    check("drain_both", 64'(exp_q.size()), 64'd0);

    // glitches shorter than the debounce window
    key_load_i = 1'b1;
    cyc(10);
    key_load_i = 1'b0;
    key_step_i = 1'b1;
    cyc(12);
    key_step_i = 1'b0;
    cyc(30);
    check("ks_glitch", {62'd0, key_state_o}, 64'd0);
    check("fsm_glitch", {60'd0, dbg_fsm_o}, 64'd0);

    // long hold: repeats only with auto-repeat built in
    e0 = edge_cnt;
    key_step_i = 1'b1;
    push_pulse(e0 + LAT, 1'b0);
`ifdef AUTO_REPEAT_EN
    for (int k = 1; e0 + LAT + REP * k < e0 + 300 + LAT; k++)
      push_pulse(e0 + LAT + REP * k, 1'b0);
`endif
    cyc(300);
    key_step_i = 1'b0;
    cyc(120);
    check("drain_hold", 64'(exp_q.size()), 64'd0);
    check("seed_final", {56'd0, seed_o}, {56'd0, exp_seed});

    // final report
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
